alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, handshaked successor to the 4-bit combinational ALU: a WIDTH-bit ALU with registered result, status flags and an optional multi-cycle shift-add multiplier. Operands enter through a valid/ready input port. Results leave through a valid/ready output port, so the block can sit between a register file and a writeback stage that may stall. One operation is in flight at a time.

## Interface
- WIDTH, 4, operand/result width in bits; legal range 2..32
- clk  in  1  rising-edge clock, sole clock domain
- rst_n  in  1  synchronous, active-low reset, sampled on rising clk
- in_valid  in  1  a/b/op valid this cycle
- in_ready  out  1  block accepts an operation this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- op  in  3  operation code (see Operation)
- out_valid  out  1  r/flags valid; held until accepted
- out_ready  in  1  consumer accepts result this cycle
- r  out  WIDTH  result
- flags  out  5  {err, v, c, n, z}

## Operation
- Op codes (package constants):
  - 000 AND
  - 001 OR
  - 010 ADD
  - 011 XOR
  - 100 MUL
  - 101 reserved
  - 110 SUB (a-b)
  - 111 SLT (signed a<b → r=1 else 0)
- States:
  - IDLE: in_ready=1. An input handshake with op≠MUL goes to DONE, with r/flags registered from the combinational result. An input handshake with MUL goes to BUSY.
  - BUSY: shift-add multiply for exactly WIDTH cycles, then DONE.
  - DONE: out_valid=1, r/flags stable. When out_ready=1, go to IDLE.
- Input operands are captured on handshake; a/b/op may change afterwards without effect.
- Arithmetic modulo 2^WIDTH.
- ADD:
  - c = carry out
  - v = signed overflow (operands same sign, result different sign)
- SUB:
  - computed as a + ~b + 1
  - c = 1 when no borrow (a ≥ b unsigned)
  - v = signed overflow
- SLT: signed compare, independent of overflow. c=0, v=0.
- AND/OR/XOR: c=0, v=0.
- MUL: r = low WIDTH bits of unsigned product. c = 1 if the high WIDTH bits are nonzero. v=0.
- All ops: z = (r==0), n = r[WIDTH-1].
- Reserved op 101, and MUL when not compiled in: r=0, err=1, z=1, others 0, latency as single-cycle ops. err=0 for every legal op.
- Reset: state→IDLE, r=0, flags=0, out_valid=0, in_ready=1 in the cycle after the reset edge. An in-progress multiply or unaccepted result is discarded.

## Timing
- Single-cycle op: input handshake in cycle T → out_valid=1 in T+1.
- MUL: input handshake in T → out_valid=1 in T+WIDTH+1.
- in_ready is 0 throughout BUSY and DONE, so no new input is accepted while a result is pending.
- Output handshake in cycle T → IDLE in T+1. The earliest next input handshake is T+1. Peak throughput is one single-cycle op per 2 cycles.
- out_valid never drops without a handshake except on reset.
- r/flags never change while out_valid=1.
- in_ready and out_valid are registered, with no combinational path from out_ready or in_valid.

## Configuration
- ALU_SEQ_MUL_EN defined: MUL (op 100) is implemented with the BUSY state and the multiplier sub-module.
- ALU_SEQ_MUL_EN undefined:
  - op 100 is handled as reserved (err=1, single-cycle)
  - BUSY is unreachable and the multiplier is not instantiated
  - all other behaviour is identical

## Structure
- Package alu_seq_pkg holds:
  - op code localparams: OP_AND, OP_OR, OP_ADD, OP_XOR, OP_MUL, OP_SUB, OP_SLT
  - state typedef: S_IDLE, S_BUSY, S_DONE
  - flag bit indices: F_Z=0, F_N=1, F_C=2, F_V=3, F_ERR=4
- One sub-module, alu_seq_mul: WIDTH-parametrised shift-add multiplier. It has a start pulse, a done pulse after exactly WIDTH cycles, and a 2·WIDTH-bit product. It is instantiated only under ALU_SEQ_MUL_EN.

## Test plan
- WIDTH=4, AND a=1110 b=1101 → one cycle later out_valid=1, r=1100, flags z=0 n=1 c=0 v=0 err=0.
- WIDTH=4, ADD a=1111 b=0001 → r=0000, z=1, c=1, v=0. ADD a=0111 b=0001 → r=1000, n=1, v=1.
- WIDTH=4, SUB a=0000 b=0001 → r=1111, c=0, n=1. SLT a=1111 b=1000 → r=0000; SLT a=0011 b=0111 → r=0001.
- WIDTH=8 with ALU_SEQ_MUL_EN, MUL a=15 b=17 → out_valid exactly 9 cycles after the handshake, r=255, c=0. MUL a=16 b=16 → r=0, c=1, z=1. Without the macro, MUL → r=0, err=1 after 1 cycle.
- Backpressure: hold out_ready=0 for 5 cycles after a result → r/flags stable, in_ready=0, later in_valid ignored. Pulse out_ready → IDLE next cycle.
- Reset mid-MUL (rst_n=0 during BUSY cycle 3) → next cycle out_valid=0, r=0, flags=0, in_ready=1. No stale result is ever presented.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared constants for the sequential ALU: op codes, FSM states, flag bit positions.
package alu_seq_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int F_Z   = 0;
  localparam int F_N   = 1;
  localparam int F_C   = 2;
  localparam int F_V   = 3;
  localparam int F_ERR = 4;

  localparam int FLAGS_W = 5;

endpackage

// File: rtl/alu_seq_mul.sv
// Shift-add unsigned multiplier: start captures operands, done pulses exactly
// WIDTH cycles later with the full 2*WIDTH-bit product valid on that cycle.
module alu_seq_mul #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic               busy;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] mcand;
  logic [WIDTH-1:0]   mplier;
  logic [2*WIDTH-1:0] acc_next;

  // The final iteration's sum is presented directly so the product is ready on the done cycle.
  assign acc_next = mplier[0] ? (acc + mcand) : acc;
  assign done     = busy && (cnt == CW'(WIDTH - 1));
  assign product  = acc_next;

  // Iteration control: one partial product per cycle, stop after WIDTH of them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy <= 1'b0;
      cnt  <= '0;
    end else if (start) begin
      busy <= 1'b1;
      cnt  <= '0;
    end else if (busy) begin
      cnt <= cnt + CW'(1);
      if (done) busy <= 1'b0;
    end
  end

  // Datapath: accumulate shifted multiplicand for each set multiplier bit.
  always_ff @(posedge clk) begin
    if (start) begin
      acc    <= '0;
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked WIDTH-bit ALU with registered result and flags {err,v,c,n,z}.
// Build option: define ALU_SEQ_MUL_EN to implement op 100 (MUL) with the
// multi-cycle shift-add multiplier; otherwise op 100 behaves as reserved.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2:0]         op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   r,
  output logic [FLAGS_W-1:0] flags
);

  // Single-cycle ALU evaluation; returns {flags, result}.
  function automatic logic [WIDTH+FLAGS_W-1:0] alu_eval(
    input logic [WIDTH-1:0] x,
    input logic [WIDTH-1:0] y,
    input logic [2:0]       code
  );
    logic [WIDTH:0]           sum;
    logic [WIDTH-1:0]         res;
    logic signed [WIDTH-1:0]  sx;
    logic signed [WIDTH-1:0]  sy;
    logic [FLAGS_W-1:0]       f;
    sx  = x;
    sy  = y;
    sum = '0;
    res = '0;
    f   = '0;
    case (code)
      OP_AND: res = x & y;
      OP_OR:  res = x | y;
      OP_XOR: res = x ^ y;
      OP_ADD: begin
        sum      = {1'b0, x} + {1'b0, y};
        res      = sum[WIDTH-1:0];
        f[F_C]   = sum[WIDTH];
        f[F_V]   = (x[WIDTH-1] == y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        // Carry out of a + ~b + 1 is the "no borrow" indication.
        sum      = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};
        res      = sum[WIDTH-1:0];
        f[F_C]   = sum[WIDTH];
        f[F_V]   = (x[WIDTH-1] != y[WIDTH-1]) && (res[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SLT: res = {{(WIDTH-1){1'b0}}, (sx < sy)};
      // Reserved code, and MUL when the multiplier is not built in.
      default: f[F_ERR] = 1'b1;
    endcase
    f[F_Z] = (res == '0);
    f[F_N] = res[WIDTH-1];
    return {f, res};
  endfunction

  state_t                   state_q;
  state_t                   state_d;
  logic [WIDTH-1:0]         r_q;
  logic [FLAGS_W-1:0]       flags_q;
  logic                     accept;
  logic                     is_mul;
  logic                     mul_done;
  logic [WIDTH-1:0]         mul_r;
  logic [FLAGS_W-1:0]       mul_flags;
  logic [WIDTH+FLAGS_W-1:0] alu_out;

  assign accept  = (state_q == S_IDLE) && in_valid;
  assign alu_out = alu_eval(a, b, op);

`ifdef ALU_SEQ_MUL_EN
  logic [2*WIDTH-1:0] product;

  assign is_mul = (op == OP_MUL);

  alu_seq_mul #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (accept && is_mul),
    .a       (a),
    .b       (b),
    .done    (mul_done),
    .product (product)
  );

  // MUL flags: carry marks a product that does not fit in WIDTH bits.
  always_comb begin
    mul_r            = product[WIDTH-1:0];
    mul_flags        = '0;
    mul_flags[F_Z]   = (mul_r == '0);
    mul_flags[F_N]   = mul_r[WIDTH-1];
    mul_flags[F_C]   = |product[2*WIDTH-1:WIDTH];
  end
`else
  assign is_mul    = 1'b0;
  assign mul_done  = 1'b0;
  assign mul_r     = '0;
  assign mul_flags = '0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: one operation in flight, result held until accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = is_mul ? S_BUSY : S_DONE;
      S_BUSY:  if (mul_done) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Result/flags capture; cleared on reset so no stale value survives it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q     <= '0;
      flags_q <= '0;
    end else if (accept && !is_mul) begin
      r_q     <= alu_out[WIDTH-1:0];
      flags_q <= alu_out[WIDTH+FLAGS_W-1:WIDTH];
    end else if ((state_q == S_BUSY) && mul_done) begin
      r_q     <= mul_r;
      flags_q <= mul_flags;
    end
  end

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign r         = r_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: a WIDTH=4 instance for the logic/arithmetic
// vectors and a WIDTH=8 instance for multiply and reset-during-operation.
module tb_alu_seq;
  import alu_seq_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       iv4, ir4, ov4, or4;
  logic [3:0] a4, b4, r4;
  logic [2:0] op4;
  logic [4:0] f4;

  logic       iv8, ir8, ov8, or8;
  logic [7:0] a8, b8, r8;
  logic [2:0] op8;
  logic [4:0] f8;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4), .a(a4), .b(b4),
    .op(op4), .out_valid(ov4), .out_ready(or4), .r(r4), .flags(f4)
  );

  alu_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8), .a(a8), .b(b8),
    .op(op8), .out_valid(ov8), .out_ready(or8), .r(r8), .flags(f8)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operation and complete the input handshake, then scramble operands.
  task automatic issue(input bit big, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] op, input string tag);
    @(negedge clk);
    if (big) begin iv8 = 1'b1; a8 = a; b8 = b; op8 = op; end
    else begin iv4 = 1'b1; a4 = a[3:0]; b4 = b[3:0]; op4 = op; end
    chk({tag, ".in_ready"}, big ? ir8 : ir4, 32'd1);
    @(posedge clk); #1;
    if (big) begin iv8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 3'($urandom); end
    else begin iv4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); op4 = 3'($urandom); end
  endtask

  // Wait (bounded) for out_valid and check latency, result and flags.
  task automatic expect_out(input bit big, input int lat, input logic [7:0] er,
                            input logic [4:0] ef, input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(big ? ov8 : ov4) && n < 40);
    chk({tag, ".latency"}, n, lat);
    chk({tag, ".r"}, big ? {24'd0, r8} : {28'd0, r4}, {24'd0, er});
    chk({tag, ".flags"}, big ? f8 : f4, ef);
    chk({tag, ".in_ready_busy"}, big ? ir8 : ir4, 32'd0);
  endtask

  // Accept the pending result with a one-cycle out_ready pulse.
  task automatic take(input bit big, input string tag);
    if (big) or8 = 1'b1; else or4 = 1'b1;
    @(posedge clk); #1;
    if (big) or8 = 1'b0; else or4 = 1'b0;
    @(negedge clk);
    chk({tag, ".out_valid_after"}, big ? ov8 : ov4, 32'd0);
    chk({tag, ".in_ready_after"}, big ? ir8 : ir4, 32'd1);
  endtask

  task automatic run(input bit big, input logic [7:0] a, input logic [7:0] b,
                     input logic [2:0] op, input int lat, input logic [7:0] er,
                     input logic [4:0] ef, input string tag);
    issue(big, a, b, op, tag);
    expect_out(big, lat, er, ef, tag);
    take(big, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    iv4 = 1'b0; or4 = 1'b0; a4 = '0; b4 = '0; op4 = '0;
    iv8 = 1'b0; or8 = 1'b0; a8 = '0; b8 = '0; op8 = '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("reset.out_valid4", ov4, 32'd0);
    chk("reset.in_ready4", ir4, 32'd1);
    chk("reset.r4", r4, 32'd0);
    chk("reset.flags4", f4, 32'd0);
    chk("reset.out_valid8", ov8, 32'd0);
    chk("reset.in_ready8", ir8, 32'd1);

    // WIDTH=4 single-cycle vectors
    run(0, 8'hE, 8'hD, OP_AND, 1, 8'hC, 5'h02, "and");
    run(0, 8'hF, 8'h1, OP_ADD, 1, 8'h0, 5'h05, "add_carry");
    run(0, 8'h7, 8'h1, OP_ADD, 1, 8'h8, 5'h0A, "add_ovf");
    run(0, 8'h0, 8'h1, OP_SUB, 1, 8'hF, 5'h02, "sub_borrow");
    run(0, 8'h5, 8'h3, OP_SUB, 1, 8'h2, 5'h04, "sub_noborrow");
    run(0, 8'h8, 8'h1, OP_SUB, 1, 8'h7, 5'h0C, "sub_ovf");
    run(0, 8'hF, 8'h8, OP_SLT, 1, 8'h0, 5'h01, "slt_false");
    run(0, 8'h3, 8'h7, OP_SLT, 1, 8'h1, 5'h00, "slt_true");
    run(0, 8'hA, 8'h5, OP_OR,  1, 8'hF, 5'h02, "or");
    run(0, 8'hC, 8'hA, OP_XOR, 1, 8'h6, 5'h00, "xor");
    run(0, 8'h3, 8'h2, 3'b101, 1, 8'h0, 5'h11, "reserved");
`ifdef ALU_SEQ_MUL_EN
    run(0, 8'h3, 8'h5, OP_MUL, 5, 8'hF, 5'h02, "mul4_fit");
    run(0, 8'hF, 8'hF, OP_MUL, 5, 8'h1, 5'h04, "mul4_hi");
    run(1, 8'd15, 8'd17, OP_MUL, 9, 8'hFF, 5'h02, "mul8_255");
    run(1, 8'd16, 8'd16, OP_MUL, 9, 8'h00, 5'h05, "mul8_256");
`else
    run(0, 8'h3, 8'h5, OP_MUL, 1, 8'h0, 5'h11, "mul4_off");
    run(1, 8'd15, 8'd17, OP_MUL, 1, 8'h00, 5'h11, "mul8_off");
`endif

    // Backpressure: result held, input ignored while pending
    issue(0, 8'h7, 8'h7, OP_ADD, "bp");
    expect_out(0, 1, 8'hE, 5'h0A, "bp");
    iv4 = 1'b1; a4 = 4'h1; b4 = 4'h1; op4 = OP_AND;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp.out_valid_hold", ov4, 32'd1);
      chk("bp.r_hold", r4, 32'hE);
      chk("bp.flags_hold", f4, 32'h0A);
      chk("bp.in_ready_hold", ir4, 32'd0);
    end
    iv4 = 1'b0;
    take(0, "bp");
    @(negedge clk);
    chk("bp.no_ghost", ov4, 32'd0);

    // Reset while an operation is outstanding on the WIDTH=8 instance
`ifdef ALU_SEQ_MUL_EN
    issue(1, 8'h23, 8'h45, OP_MUL, "rst");
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rst.busy_no_valid", ov8, 32'd0);
    chk("rst.busy_in_ready", ir8, 32'd0);
`else
    issue(1, 8'h7F, 8'h01, OP_ADD, "rst");
    expect_out(1, 1, 8'h80, 5'h0A, "rst");
`endif
    rst_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst.out_valid", ov8, 32'd0);
    chk("rst.r", r8, 32'd0);
    chk("rst.flags", f8, 32'd0);
    chk("rst.in_ready", ir8, 32'd1);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("rst.no_stale", ov8, 32'd0);
    end
    run(1, 8'h01, 8'h02, OP_ADD, 1, 8'h03, 5'h00, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
